regfile_write_scheduler: RTL and testbench
==========================================

# regfile_write_scheduler

Sequences the single write port of the 16×16-bit register file. Two producers compete for it: the pipeline writeback stage and the multi-cycle load-completion path after a cache miss. The block arbitrates between them with a starvation guard and registers the winning write into a one-hot WriteReg vector, D, and a register index. It also keeps a per-register pending-write scoreboard that the hazard/stall logic reads.

## Interface
Parameters:
- STARVE_LIMIT, 3: consecutive load-path losses after which the load path wins (1..3).
- PEND_MAX, 3: maximum outstanding reservations per register (saturating 2-bit count).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_valid  in  1  writeback request.
- wb_reg  in  4  writeback destination index.
- wb_data  in  16  writeback data.
- wb_ready  out  1  writeback accepted this cycle when wb_valid && wb_ready.
- ld_valid  in  1  load-completion request.
- ld_reg  in  4  load destination index.
- ld_data  in  16  load data.
- ld_ready  out  1  load accepted this cycle when ld_valid && ld_ready.
- rsv_valid  in  1  issue stage reserves destination rsv_reg.
- rsv_reg  in  4  register being reserved.
- rsv_ready  out  1  reservation accepted when rsv_valid && rsv_ready.
- write_reg  out  16  one-hot register write enable to the file (WriteReg per register).
- wr_data  out  16  data driven to every register's D.
- wr_idx  out  4  index of the register written this cycle.
- busy  out  16  busy[i] = pending count of register i non-zero.

## Operation
- Arbitration is combinational from current state:
  - Default priority goes to writeback: wb_ready = 1 unless the starve condition holds; ld_ready = !wb_valid || starve.
  - starve = ld_valid && (starve_cnt == STARVE_LIMIT).
- starve_cnt is 2-bit:
  - Increments when ld_valid && !ld_ready.
  - Clears when a load is accepted, or when ld_valid is low.
  - Never exceeds STARVE_LIMIT.
- At most one write is accepted per cycle. The accepted request's reg/data are registered into wr_idx/wr_data, and write_reg = decode(reg) for exactly the next cycle. With no acceptance, write_reg = 0 and wr_data/wr_idx hold their last value.
- R0 writes are accepted (handshake completes) but dropped: write_reg stays 0 and the scoreboard is untouched.
- Scoreboard, one 2-bit pend[i] per register:
  - Increments on an accepted reservation of i.
  - Decrements on an accepted write to i.
  - Both in the same cycle to the same i: net unchanged.
- rsv_ready = (rsv_reg == 0) || (pend[rsv_reg] != PEND_MAX) || (a write to rsv_reg is accepted this cycle).
- Reservation of R0 is accepted and ignored.
- A write to a register with pend == 0 is still performed. The count stays 0 (no underflow), and the underflow event raises no output.

## Timing
- Reset values: write_reg = 0, wr_data = 0, wr_idx = 0, all pend = 0 (busy = 0), starve_cnt = 0. wb_ready = 1 and ld_ready = 1 during and after reset, since both are combinational from the cleared state.
- Latency: acceptance at edge N, write_reg asserted in cycle N+1, register file captures at edge N+1.
- busy deasserts in the cycle after the accepting edge. Same-cycle read bypass is not this block's job.
- Reset mid-operation: accepted-but-unwritten writes are lost, write_reg = 0 the cycle after rst, and all reservations are discarded.
- write_reg is never multi-hot.

## Structure
- Package regfile_pkg holds:
  - NUM_REGS = 16, REG_W = 16, IDX_W = 4.
  - ZERO_REG = 0.
  - STARVE_LIMIT_DEFAULT = 3.
- Sub-module write_decoder: 4-to-16 one-hot decode with an enable input. It is also reusable for the read-enable decoders.

## Test plan
- Reset then idle: rst high 2 cycles → write_reg = 0, busy = 0, wr_data = 0, wb_ready = ld_ready = rsv_ready = 1.
- Single write: wb_valid, wb_reg = 5, wb_data = 16'hBEEF at edge N → write_reg = 16'h0020, wr_data = 16'hBEEF in cycle N+1 only.
- Starvation: wb_valid and ld_valid held high 5 cycles (ld_reg = 3) → wb wins 3 cycles, ld accepted on the 4th (write_reg = 16'h0008 next cycle), wb wins the 5th.
- Scoreboard: reserve R7 three times → busy[7] = 1, and a 4th reserve has rsv_ready = 0. Reserve R7 while a write to R7 is accepted in the same cycle → reservation accepted, count stays 3. Three writes to R7 → busy[7] = 0.
- R0 handling: write R0 with 16'h1234 → handshake completes, write_reg = 0, busy unchanged. Reserve R0 → busy[0] stays 0.
- Reset mid-operation: accept write to R9, assert rst at the next edge → write_reg = 0 after reset, pend all zero.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write scheduler.
package regfile_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W = 16;
    localparam int IDX_W = 4;

    localparam logic [IDX_W-1:0] ZERO_REG = '0;
    localparam int STARVE_LIMIT_DEFAULT = 3;

    typedef logic [1:0] pend_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic [REG_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_decoder.sv
// 4-to-16 one-hot decoder with enable; shared by write and reservation paths.
module write_decoder
    import regfile_pkg::*;
(
    input  logic                en_i,
    input  logic [IDX_W-1:0]    idx_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates writeback vs. load-completion onto the single register-file
// write port and tracks outstanding reservations per destination register.
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int PEND_MAX     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_reg,
    input  logic [REG_W-1:0]    wb_data,
    output logic                wb_ready,
    input  logic                ld_valid,
    input  logic [IDX_W-1:0]    ld_reg,
    input  logic [REG_W-1:0]    ld_data,
    output logic                ld_ready,
    input  logic                rsv_valid,
    input  logic [IDX_W-1:0]    rsv_reg,
    output logic                rsv_ready,
    output logic [NUM_REGS-1:0] write_reg,
    output logic [REG_W-1:0]    wr_data,
    output logic [IDX_W-1:0]    wr_idx,
    output logic [NUM_REGS-1:0] busy
);

    localparam logic [1:0] SL = STARVE_LIMIT[1:0];
    localparam pend_t      PM = PEND_MAX[1:0];

    logic [1:0]          starve_q, starve_d;
    pend_t               pend_q [NUM_REGS];
    pend_t               pend_d [NUM_REGS];
    logic [NUM_REGS-1:0] write_reg_q, write_reg_d;
    logic [REG_W-1:0]    wr_data_q, wr_data_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;

    wr_req_t             acc;
    logic                starve;
    logic                wb_acc;
    logic                ld_acc;
    logic                wr_hit;
    logic                rsv_acc;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    always_comb begin
        starve   = ld_valid && (starve_q == SL);
        wb_ready = !starve;
        ld_ready = !wb_valid || starve;
        wb_acc   = wb_valid && wb_ready;
        ld_acc   = ld_valid && ld_ready;

        acc = '0;
        if (ld_acc) begin
            acc.vld  = 1'b1;
            acc.idx  = ld_reg;
            acc.data = ld_data;
        end else if (wb_acc) begin
            acc.vld  = 1'b1;
            acc.idx  = wb_reg;
            acc.data = wb_data;
        end

        // R0 handshakes complete but never reach the file or scoreboard
        wr_hit = acc.vld && (acc.idx != ZERO_REG);

        rsv_ready = (rsv_reg == ZERO_REG)
                 || (pend_q[rsv_reg] != PM)
                 || (wr_hit && (acc.idx == rsv_reg));
        rsv_acc = rsv_valid && rsv_ready && (rsv_reg != ZERO_REG);
    end

    write_decoder u_wr_dec (
        .en_i     (wr_hit),
        .idx_i    (acc.idx),
        .onehot_o (dec_vec)
    );

    write_decoder u_rsv_dec (
        .en_i     (rsv_acc),
        .idx_i    (rsv_reg),
        .onehot_o (inc_vec)
    );

    always_comb begin
        starve_d = starve_q;
        if (!ld_valid || ld_acc) begin
            starve_d = '0;
        end else if (starve_q != SL) begin
            starve_d = starve_q + 2'd1;
        end

        write_reg_d = dec_vec;
        wr_data_d   = wr_data_q;
        wr_idx_d    = wr_idx_q;
        if (acc.vld) begin
            wr_data_d = acc.data;
            wr_idx_d  = acc.idx;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_d[i] = pend_q[i];
            case ({inc_vec[i], dec_vec[i]})
                2'b10: begin
                    if (pend_q[i] != PM) begin
                        pend_d[i] = pend_q[i] + 2'd1;
                    end
                end
                // a write with nothing pending is still performed; count stays 0
                2'b01: begin
                    if (pend_q[i] != '0) begin
                        pend_d[i] = pend_q[i] - 2'd1;
                    end
                end
                default: pend_d[i] = pend_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            write_reg_q <= '0;
            wr_data_q   <= '0;
            wr_idx_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            starve_q    <= starve_d;
            write_reg_q <= write_reg_d;
            wr_data_q   <= wr_data_d;
            wr_idx_q    <= wr_idx_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy[i] = (pend_q[i] != '0);
        end
    end

    assign write_reg = write_reg_q;
    assign wr_data   = wr_data_q;
    assign wr_idx    = wr_idx_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed plus randomized bench for regfile_write_scheduler against a reference model.
module tb_regfile_write_scheduler;

    localparam int STARVE = 3;
    localparam int PMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, ld_valid, rsv_valid;
    logic [3:0]  wb_reg, ld_reg, rsv_reg;
    logic [15:0] wb_data, ld_data;
    logic        wb_ready, ld_ready, rsv_ready;
    logic [15:0] write_reg, wr_data, busy;
    logic [3:0]  wr_idx;

    always #5 clk = ~clk;

    regfile_write_scheduler #(.STARVE_LIMIT(STARVE), .PEND_MAX(PMAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .ld_valid  (ld_valid),
        .ld_reg    (ld_reg),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .rsv_ready (rsv_ready),
        .write_reg (write_reg),
        .wr_data   (wr_data),
        .wr_idx    (wr_idx),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // reference model: outstanding counts, loss streak, expected registered outputs
    int          m_pend [16];
    int          m_scnt;
    logic [15:0] m_wreg, m_data;
    logic [3:0]  m_idx;
    bit          m_known;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_scnt = 0;
        m_wreg = '0;
        m_data = '0;
        m_idx = '0;
        m_known = 1'b1;
    endtask

    task automatic cyc(input bit r, input bit wv, input logic [3:0] wr,
                       input logic [15:0] wd, input bit lv,
                       input logic [3:0] lr, input logic [15:0] ld,
                       input bit rv, input logic [3:0] rr);
        bit          starve, wrdy, lrdy, wacc, lacc, hit, rrdy, racc;
        logic [3:0]  areg;
        logic [15:0] adata, bexp;
        @(negedge clk);
        rst = r;
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        ld_valid = lv; ld_reg = lr; ld_data = ld;
        rsv_valid = rv; rsv_reg = rr;
        #1;
        starve = lv && (m_scnt == STARVE);
        wrdy = !starve;
        lrdy = !wv || starve;
        wacc = wv && wrdy;
        lacc = lv && lrdy;
        areg = lacc ? lr : wr;
        adata = lacc ? ld : wd;
        hit = (wacc || lacc) && (areg != 0);
        rrdy = (rr == 0) || (m_pend[rr] < PMAX) || (hit && areg == rr);
        racc = rv && rrdy;
        check("wb_ready", 32'(wb_ready), 32'(wrdy));
        check("ld_ready", 32'(ld_ready), 32'(lrdy));
        check("rsv_ready", 32'(rsv_ready), 32'(rrdy));
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            m_scnt = (!lv || lacc) ? 0 : ((m_scnt < STARVE) ? m_scnt + 1 : STARVE);
            m_wreg = hit ? (16'd1 << areg) : 16'd0;
            if (wacc || lacc) begin
                m_idx = areg;
                m_data = adata;
                m_known = hit;
            end
            if (!(hit && racc && rr == areg)) begin
                if (hit && m_pend[areg] > 0) m_pend[areg]--;
                if (racc && rr != 0) m_pend[rr]++;
            end
        end
        bexp = '0;
        for (int i = 0; i < 16; i++) bexp[i] = (m_pend[i] != 0);
        check("write_reg", 32'(write_reg), 32'(m_wreg));
        check("busy", 32'(busy), 32'(bexp));
        if (m_known) begin
            check("wr_data", 32'(wr_data), 32'(m_data));
            check("wr_idx", 32'(wr_idx), 32'(m_idx));
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 0; wb_reg = 0; wb_data = 0;
        ld_valid = 0; ld_reg = 0; ld_data = 0;
        rsv_valid = 0; rsv_reg = 0;
        model_reset();

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_write_reg", 32'(write_reg), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_rdys", {29'd0, wb_ready, ld_ready, rsv_ready}, 32'h7);
        idle();

        cyc(0, 1, 5, 16'hBEEF, 0, 0, 0, 0, 0);
        check("single_wreg", 32'(write_reg), 32'h0020);
        check("single_data", 32'(wr_data), 32'hBEEF);
        idle();
        check("single_off", 32'(write_reg), 32'h0);

        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 1, 16'h1000 + 16'(k), 1, 3, 16'hA000 + 16'(k), 0, 0);
            if (k == 0) check("starve_wb0", 32'(write_reg), 32'h0002);
            if (k == 3) check("starve_ld", 32'(write_reg), 32'h0008);
            if (k == 4) check("starve_wb4", 32'(write_reg), 32'h0002);
        end
        idle();

        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
        check("sb_busy7", 32'(busy[7]), 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
        cyc(0, 1, 7, 16'h7777, 0, 0, 0, 1, 7);
        check("sb_still", 32'(busy[7]), 32'h1);
        repeat (3) cyc(0, 1, 7, 16'h0707, 0, 0, 0, 0, 0);
        check("sb_clear7", 32'(busy[7]), 32'h0);

        cyc(0, 1, 0, 16'h1234, 0, 0, 0, 0, 0);
        check("r0_wreg", 32'(write_reg), 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("r0_busy", 32'(busy), 32'h0);

        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4);
        cyc(0, 1, 9, 16'h9999, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("mid_rst_wreg", 32'(write_reg), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        idle();

        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 79) == 0),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                16'($urandom),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                16'($urandom),
                ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 5)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
